// File: rtl/kbd_seg_driver.sv
// PS/2 set-2 scan-code front end for six 7-seg digits: code, ASCII, BCD press count.
// Optional scan-code->ASCII table enabled by defining KBD_ASCII_EN.
module kbd_seg_driver #(
  parameter int unsigned CNT_MAX  = 99,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [23:0] dig_o,
  output logic [5:0]  off_o
);

  typedef enum logic [1:0] {IDLE, PRESSED, BREAK} state_e;

  localparam logic [7:0] BYTE_E0  = 8'hE0;
  localparam logic [7:0] BYTE_F0  = 8'hF0;
  localparam logic [3:0] MAX_ONES = 4'(CNT_MAX % 10);
  localparam logic [3:0] MAX_TENS = 4'(CNT_MAX / 10);

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       held_q, held_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       ready_q;
  logic       accept;
  logic       inc;

  assign ready_o = ready_q & ~rst;
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      held_q  <= 1'b0;
      ones_q  <= '0;
      tens_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      held_q  <= held_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      ready_q <= ~accept;
    end
  end

  // held_q remembers whether a key is down, so BREAK can return to the right state
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    held_d  = held_q;
    inc     = 1'b0;
    if (accept && data_i != BYTE_E0) begin
      unique case (state_q)
        IDLE: begin
          if (data_i == BYTE_F0) begin
            state_d = BREAK;
          end else begin
            code_d  = data_i;
            held_d  = 1'b1;
            inc     = 1'b1;
            state_d = PRESSED;
          end
        end
        PRESSED: begin
          if (data_i == BYTE_F0) begin
            state_d = BREAK;
          end else if (data_i != code_q) begin
            code_d = data_i;
            inc    = 1'b1;
          end
        end
        BREAK: begin
          if (data_i == code_q) begin
            state_d = IDLE;
            held_d  = 1'b0;
          end else begin
            state_d = held_q ? PRESSED : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (inc) begin
      if (ones_q == MAX_ONES && tens_q == MAX_TENS) begin
        ones_d = '0;
        tens_d = '0;
      end else if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

`ifdef KBD_ASCII_EN
  logic [7:0] asc;
  logic       asc_ok;

  always_comb begin
    asc    = '0;
    asc_ok = 1'b1;
    case (code_q)
      8'h1C: asc = 8'h61;  8'h32: asc = 8'h62;  8'h21: asc = 8'h63;  8'h23: asc = 8'h64;
      8'h24: asc = 8'h65;  8'h2B: asc = 8'h66;  8'h34: asc = 8'h67;  8'h33: asc = 8'h68;
      8'h43: asc = 8'h69;  8'h3B: asc = 8'h6A;  8'h42: asc = 8'h6B;  8'h4B: asc = 8'h6C;
      8'h3A: asc = 8'h6D;  8'h31: asc = 8'h6E;  8'h44: asc = 8'h6F;  8'h4D: asc = 8'h70;
      8'h15: asc = 8'h71;  8'h2D: asc = 8'h72;  8'h1B: asc = 8'h73;  8'h2C: asc = 8'h74;
      8'h3C: asc = 8'h75;  8'h2A: asc = 8'h76;  8'h1D: asc = 8'h77;  8'h22: asc = 8'h78;
      8'h35: asc = 8'h79;  8'h1A: asc = 8'h7A;
      8'h45: asc = 8'h30;  8'h16: asc = 8'h31;  8'h1E: asc = 8'h32;  8'h26: asc = 8'h33;
      8'h25: asc = 8'h34;  8'h2E: asc = 8'h35;  8'h36: asc = 8'h36;  8'h3D: asc = 8'h37;
      8'h3E: asc = 8'h38;  8'h46: asc = 8'h39;
      default: asc_ok = 1'b0;
    endcase
  end
`endif

  always_comb begin
    dig_o = {tens_q, ones_q, 8'h00, code_q};
    off_o = {LZ_BLANK && (tens_q == 4'd0), 1'b0, 2'b11, ~held_q, ~held_q};
`ifdef KBD_ASCII_EN
    if (held_q && asc_ok) begin
      dig_o[15:8] = asc;
      off_o[3:2]  = 2'b00;
    end
`endif
  end

endmodule

// File: tb/tb_kbd_seg_driver.sv
// Self-checking bench for kbd_seg_driver: directed vector table, corner sequences,
// and randomized bytes against a behavioural key/count model.
module tb_kbd_seg_driver;

  localparam int unsigned CNT_MAX = 99;
  localparam bit          LZ      = 1'b1;
`ifdef KBD_ASCII_EN
  localparam bit ASC = 1'b1;
`else
  localparam bit ASC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [23:0] dig_o;
  logic [5:0]  off_o;

  kbd_seg_driver #(.CNT_MAX(CNT_MAX), .LZ_BLANK(LZ)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .dig_o(dig_o), .off_o(off_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: key held?, last code, pending break, integer press count
  int         m_cnt;
  logic [7:0] m_code;
  bit         m_held;
  bit         m_brk;
  logic [7:0] asc_tab [256];

  typedef struct {
    logic [7:0] data;
    logic [7:0] code;
    logic [7:0] cnt;
    logic [1:0] offlo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_code = '0; m_held = 0; m_brk = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (m_brk) begin
      m_brk = 0;
      if (b == m_code) m_held = 0;
      return;
    end
    if (b == 8'hF0) begin
      m_brk = 1;
      return;
    end
    if (!m_held || b != m_code) begin
      m_code = b;
      m_held = 1;
      m_cnt  = (m_cnt + 1) % (CNT_MAX + 1);
    end
  endfunction

  task automatic check_model(input string tag);
    logic [3:0] t, o;
    logic [7:0] a;
    logic       sh;
    t  = 4'(m_cnt / 10);
    o  = 4'(m_cnt % 10);
    a  = asc_tab[m_code];
    sh = ASC && m_held && (a != 8'h00);
    chk({tag, "_dig"}, 32'({t, o, (sh ? a : 8'h00), m_code}), 32'(dig_o));
    chk({tag, "_off"}, 32'(off_o), 32'({(LZ && t == 4'd0), 1'b0, ~sh, ~sh, ~m_held, ~m_held}));
  endtask

  // wait (bounded) for ready, present one byte for one accept edge, then check
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready_o stuck at 0, expected 1");
      return;
    end
    data_i  = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    model_byte(b);
    check_model("send");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("ready_in_rst", 32'(ready_o), 32'd0);
    rst = 1'b0;
    model_reset();
    #1 chk("ready_after_rst", 32'(ready_o), 32'd1);
    check_model("rst");
  endtask

  initial begin
    logic [7:0] codes [36];
    string      chars;
    vec_t       vt [26];
    logic [7:0] pool [8];
    logic [7:0] seq [4];
    int         acc, k, tog;
    logic       rdy, prev_rdy;

    codes = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
              8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,
              8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    chars = "abcdefghijklmnopqrstuvwxyz0123456789";
    for (int i = 0; i < 256; i++) asc_tab[i] = 8'h00;
    for (int i = 0; i < 36; i++) asc_tab[codes[i]] = chars[i];

    vt = '{
      '{8'h1C, 8'h1C, 8'h01, 2'b00}, '{8'hF0, 8'h1C, 8'h01, 2'b00}, '{8'h1C, 8'h1C, 8'h01, 2'b11},
      '{8'h1C, 8'h1C, 8'h02, 2'b00}, '{8'h1C, 8'h1C, 8'h02, 2'b00}, '{8'h1C, 8'h1C, 8'h02, 2'b00},
      '{8'h1C, 8'h1C, 8'h02, 2'b00}, '{8'h1C, 8'h1C, 8'h02, 2'b00}, '{8'hF0, 8'h1C, 8'h02, 2'b00},
      '{8'h1C, 8'h1C, 8'h02, 2'b11}, '{8'h1C, 8'h1C, 8'h03, 2'b00}, '{8'h1B, 8'h1B, 8'h04, 2'b00},
      '{8'hF0, 8'h1B, 8'h04, 2'b00}, '{8'h1B, 8'h1B, 8'h04, 2'b11}, '{8'hE0, 8'h1B, 8'h04, 2'b11},
      '{8'h75, 8'h75, 8'h05, 2'b00}, '{8'hF0, 8'h75, 8'h05, 2'b00}, '{8'hE0, 8'h75, 8'h05, 2'b00},
      '{8'h75, 8'h75, 8'h05, 2'b11}, '{8'hF0, 8'h75, 8'h05, 2'b11}, '{8'h16, 8'h75, 8'h05, 2'b11},
      '{8'h16, 8'h16, 8'h06, 2'b00}, '{8'hF0, 8'h16, 8'h06, 2'b00}, '{8'h1C, 8'h16, 8'h06, 2'b00},
      '{8'h16, 8'h16, 8'h06, 2'b00}, '{8'hE0, 8'h16, 8'h06, 2'b00}
    };

    // reset, then idle
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    chk("idle_off", 32'(off_o), 32'b101111);
    chk("idle_dig", 32'(dig_o), 32'd0);
    chk("idle_ready", 32'(ready_o), 32'd1);

    // directed vector table
    for (int i = 0; i < 26; i++) begin
      send(vt[i].data);
      chk($sformatf("vec%0d_code", i), 32'(dig_o[7:0]), 32'(vt[i].code));
      chk($sformatf("vec%0d_cnt", i), 32'(dig_o[23:16]), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_off", i), 32'(off_o[1:0]), 32'(vt[i].offlo));
    end

    // reset asserted together with valid: byte dropped
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b1; data_i = 8'h1C;
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;
    model_reset();
    #1 check_model("rst_valid");

    // reset after F0 loses the pending break
    send(8'h1C);
    send(8'hF0);
    do_reset();
    chk("midrst_cnt", 32'(dig_o[23:16]), 32'd0);
    send(8'h1C);
    chk("midrst_press_cnt", 32'(dig_o[23:16]), 32'h01);
    chk("midrst_press_off", 32'(off_o[1:0]), 32'd0);

    // 100 make/break pairs: 99 then wrap to 00 with tens blanked
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      send(8'h1C);
      if (i == 99) chk("cnt_99", 32'(dig_o[23:16]), 32'h99);
      if (i == 100) begin
        chk("cnt_wrap", 32'(dig_o[23:16]), 32'h00);
        chk("cnt_wrap_blank", 32'(off_o[5]), 32'd1);
      end
      send(8'hF0);
      send(8'h1C);
    end

    // valid held continuously: one accept per two cycles
    seq = '{8'h16, 8'hF0, 8'h16, 8'h1E};
    acc = 0; k = 0; tog = 0; prev_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      data_i  = seq[k % 4];
      valid_i = 1'b1;
      rdy     = ready_o;
      if (i > 0 && rdy != prev_rdy) tog++;
      prev_rdy = rdy;
      @(posedge clk);
      if (rdy) begin
        model_byte(seq[k % 4]);
        k++;
        acc++;
      end
    end
    #1 valid_i = 1'b0;
    chk("stream_accepts", 32'(acc), 32'd10);
    chk("stream_toggles", 32'(tog), 32'd19);
    check_model("stream");

`ifdef KBD_ASCII_EN
    do_reset();
    send(8'h45);
    chk("asc_0", 32'(dig_o[15:8]), 32'h30);
    chk("asc_0_off", 32'(off_o[3:2]), 32'd0);
    send(8'hF0);
    send(8'h45);
    send(8'h1A);
    chk("asc_z", 32'(dig_o[15:8]), 32'h7A);
    send(8'h0E);
    chk("asc_unmapped_off", 32'(off_o[3:2]), 32'b11);
`endif

    // randomized traffic with occasional resets
    pool = '{8'h1C, 8'h1B, 8'h45, 8'h0E, 8'hF0, 8'hE0, 8'h75, 8'h16};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      send(pool[$urandom_range(0, 7)]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
